// File: rtl/draw_cmd_scheduler.sv
// draw_cmd_scheduler: pops draw commands from the FIFO and runs each on its matching engine, one at a time
// Ports: clk, rst (async, active-high); enb gates new starts; ff_empty/ff_rden/ff_rdat/ff_rvld FIFO read side
//   (data returns one cycle after ff_rden); eng_dat/eng_vld start one engine and eng_done reports completion;
//   busy, err_opcode, err_timeout and cmd_cnt report status. Every output is a flop.
module draw_cmd_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 4,
  parameter int NUM_ENG = 3,
  parameter logic [OP_WIDTH-1:0] OP_ENG0 = 4'h0,
  parameter logic [OP_WIDTH-1:0] OP_ENG1 = 4'h1,
  parameter logic [OP_WIDTH-1:0] OP_ENG2 = 4'h9,
  parameter int TIMEOUT_WIDTH = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = 20'd999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  ff_empty,
  output logic                  ff_rden,
  input  logic [DATA_WIDTH-1:0] ff_rdat,
  input  logic                  ff_rvld,
  output logic [DATA_WIDTH-1:0] eng_dat,
  output logic [NUM_ENG-1:0]    eng_vld,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic                  busy,
  output logic                  err_opcode,
  output logic                  err_timeout,
  output logic [15:0]           cmd_cnt
);
  localparam int SW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [OP_WIDTH-1:0] OPS [3] = '{OP_ENG0, OP_ENG1, OP_ENG2};
  typedef enum logic [2:0] {IDLE, POP, WAIT_RD, ISSUE, WAIT_DONE} state_t;
  state_t r_state, w_state;
  logic [TIMEOUT_WIDTH-1:0] r_wd, w_wd;
  logic [SW-1:0] r_sel, w_sel, w_dsel;
  logic [DATA_WIDTH-1:0] r_dat, w_dat;
  logic [15:0] r_cnt, w_cnt;
  logic [NUM_ENG-1:0] r_vld;
  logic [OP_WIDTH-1:0] w_op;
  logic r_rden, r_busy, r_eo, r_et, w_eo, w_et, w_hit;
  assign w_op = ff_rdat[DATA_WIDTH-1 -: OP_WIDTH];
  // descending scan so the lowest matching engine index wins on duplicate opcodes
  always_comb begin
    w_hit = 1'b0;
    w_dsel = '0;
    for (int k = 2; k >= 0; k--)
      if (k < NUM_ENG && w_op == OPS[k]) begin
        w_hit = 1'b1;
        w_dsel = SW'(k);
      end
  end
  always_comb begin
    w_state = r_state;
    w_wd = r_wd;
    w_sel = r_sel;
    w_dat = r_dat;
    w_cnt = r_cnt;
    w_eo = 1'b0;
    case (r_state)
      IDLE: w_state = (enb && !ff_empty) ? POP : IDLE;
      POP: begin
        w_state = WAIT_RD;
        w_wd = '0;
      end
      WAIT_RD:
        if (r_wd == TIMEOUT_MAX) w_state = IDLE;
        else if (ff_rvld) begin
          w_dat = ff_rdat;
          w_sel = w_dsel;
          w_state = w_hit ? ISSUE : IDLE;
          w_eo = !w_hit;
        end else w_wd = r_wd + 1'b1;
      ISSUE: begin
        w_state = WAIT_DONE;
        w_wd = '0;
      end
      WAIT_DONE:
        if (r_wd == TIMEOUT_MAX) w_state = IDLE;
        else if (eng_done[r_sel]) begin
          w_cnt = r_cnt + 16'd1;
          w_state = IDLE;
        end else w_wd = r_wd + 1'b1;
      default: w_state = IDLE;
    endcase
    // the error pulse coincides with the watchdog reaching the limit; the abort to IDLE follows one cycle later
    w_et = (w_state == WAIT_RD || w_state == WAIT_DONE) && w_wd == TIMEOUT_MAX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_wd <= '0;
      r_sel <= '0;
      r_dat <= '0;
      r_cnt <= '0;
      r_vld <= '0;
      r_rden <= 1'b0;
      r_busy <= 1'b0;
      r_eo <= 1'b0;
      r_et <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wd <= w_wd;
      r_sel <= w_sel;
      r_dat <= w_dat;
      r_cnt <= w_cnt;
      r_vld <= (w_state == ISSUE) ? NUM_ENG'(1'b1) << w_sel : '0;
      r_rden <= w_state == POP;
      r_busy <= w_state != IDLE;
      r_eo <= w_eo;
      r_et <= w_et;
    end
  assign ff_rden = r_rden;
  assign eng_dat = r_dat;
  assign eng_vld = r_vld;
  assign busy = r_busy;
  assign err_opcode = r_eo;
  assign err_timeout = r_et;
  assign cmd_cnt = r_cnt;
endmodule
